serial_subtractor: RTL

Bit-serial binary subtractor computing A - B one bit per clock, LSB first. Each step uses a half-subtractor pair (difference XOR, borrow generate) plus a registered borrow. It is the inverse-operation counterpart to the combinational adder cells in the arithmetic library. It trades latency for a single full-subtractor slice, for area-constrained datapaths and ALU test fixtures.

---
 rtl/serial_subtractor_if.sv | 33 +++
 rtl/serial_subtractor.sv | 109 ++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle for serial_subtractor: start request with operands
// from the requester, busy/done status and result back from the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;

    modport master (
        output i_start,
        output i_a,
        output i_b,
        input  o_busy,
        input  o_done,
        input  o_diff,
        input  o_borrow
    );

    modport slave (
        input  i_start,
        input  i_a,
        input  i_b,
        output o_busy,
        output o_done,
        output o_diff,
        output o_borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B one bit per clock, LSB first, using one
// full-subtractor slice and a registered borrow.
// Optional build macro SERIAL_SUB_SAT_EN: saturating unsigned subtract
// (result forced to zero when the final borrow is set).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for i_start; outputs hold the last result
// RUN   | one bit processed per cycle, WIDTH cycles
// DONE  | single cycle, o_done pulses with the full result
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             d_bit;
    logic             br_next;

    // Full-subtractor slice on the current LSBs and the running borrow.
    always_comb begin
        d_bit   = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    end

    // Sequencer, operand shifters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        a_sh     <= bus.i_a;
                        b_sh     <= bus.i_b;
                        br       <= 1'b0;
                        cnt      <= '0;
                        diff_q   <= '0;
                        borrow_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_next;
                    diff_q <= {d_bit, diff_q[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state    <= DONE;
                        done_q   <= 1'b1;
                        borrow_q <= br_next;
`ifdef SERIAL_SUB_SAT_EN
                        // Underflow clamps to zero; borrow still reports it.
                        if (br_next) begin
                            diff_q <= '0;
                        end
`endif
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
    assign bus.o_diff   = diff_q;
    assign bus.o_borrow = borrow_q;

endmodule
